// File: rtl/mem_access_stage.sv
// Memory stage: data-bus request/ack FSM, store lane alignment and load extension.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_RFWe,
  input  logic [1:0]  mem_RFWsrc,
  input  logic        mem_DMre,
  input  logic        mem_DMwe,
  input  logic        mem_DMsign,
  input  logic [1:0]  mem_DMwidth,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_aluout,
  input  logic [31:0] mem_rs2data,
  input  logic [4:0]  mem_rfwaddr,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic        mem_stall,
  output logic        out_RFWe,
  output logic [4:0]  out_rfwaddr,
  output logic [31:0] out_rfwdata,
  output logic        mem_buserr,
  output logic        mem_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        access;
  logic        is_load;
  logic        mis;
  logic        go;
  logic        timeout;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] load_ext;

  assign access  = mem_DMre | mem_DMwe;
  assign is_load = mem_DMre & ~mem_DMwe;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = access &
               (((mem_DMwidth == 2'b01) & mem_aluout[0]) |
                (mem_DMwidth[1] & (|mem_aluout[1:0])));
`else
  assign mis = 1'b0;
`endif

  assign go      = access & ~mis;
  assign timeout = (state_q == REQ) & ~dm_ack &
                   (cnt_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = mem_DMwe;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      REQ: begin
        if (dm_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = dm_rdata;
        end else if (timeout) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign dm_req  = req_q;
  assign dm_we   = we_q;
  assign dm_addr = {mem_aluout[31:2], 2'b00};

  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = mem_rs2data;
    unique case (1'b1)
      (mem_DMwidth == 2'b00): begin
        dm_be    = 4'b0001 << mem_aluout[1:0];
        dm_wdata = {4{mem_rs2data[7:0]}};
      end
      (mem_DMwidth == 2'b01): begin
        dm_be    = mem_aluout[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{mem_rs2data[15:0]}};
      end
      default: begin
        dm_be    = 4'b1111;
        dm_wdata = mem_rs2data;
      end
    endcase
  end

  assign lb = rdata_q[{mem_aluout[1:0], 3'b000} +: 8];
  assign lh = mem_aluout[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    unique case (mem_DMwidth)
      2'b00:   load_ext = {{24{mem_DMsign & lb[7]}}, lb};
      2'b01:   load_ext = {{16{mem_DMsign & lh[15]}}, lh};
      default: load_ext = rdata_q;
    endcase
  end

  // Memory data only reaches the register file from a completed load.
  always_comb begin
    unique case (mem_RFWsrc)
      2'b01:   out_rfwdata = mem_aluout;
      2'b11:   out_rfwdata = mem_pc + 32'd4;
      2'b10:   out_rfwdata = ((state_q == DONE) && is_load && !abort_q)
                             ? load_ext : 32'd0;
      default: out_rfwdata = 32'd0;
    endcase
  end

  assign out_rfwaddr = mem_rfwaddr;

  always_comb begin
    mem_stall = 1'b0;
    out_RFWe  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          mem_stall = go;
          out_RFWe  = mem_RFWe & ~access;
        end
        REQ:  mem_stall = 1'b1;
        DONE: out_RFWe = mem_RFWe & ~abort_q;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  assign mem_misalign = !rst && (state_q == IDLE) && mis;
  assign mem_buserr   = timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with WAIT_MAX=4.
// Covers reset, loads, stores, PC+4 writeback, timeout and misalignment.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        mem_RFWe;
  logic [1:0]  mem_RFWsrc;
  logic        mem_DMre;
  logic        mem_DMwe;
  logic        mem_DMsign;
  logic [1:0]  mem_DMwidth;
  logic [31:0] mem_pc;
  logic [31:0] mem_aluout;
  logic [31:0] mem_rs2data;
  logic [4:0]  mem_rfwaddr;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        mem_stall;
  logic        out_RFWe;
  logic [4:0]  out_rfwaddr;
  logic [31:0] out_rfwdata;
  logic        mem_buserr;
  logic        mem_misalign;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.WAIT_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_RFWe(mem_RFWe), .mem_RFWsrc(mem_RFWsrc),
    .mem_DMre(mem_DMre), .mem_DMwe(mem_DMwe),
    .mem_DMsign(mem_DMsign), .mem_DMwidth(mem_DMwidth),
    .mem_pc(mem_pc), .mem_aluout(mem_aluout),
    .mem_rs2data(mem_rs2data), .mem_rfwaddr(mem_rfwaddr),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata),
    .mem_stall(mem_stall), .out_RFWe(out_RFWe),
    .out_rfwaddr(out_rfwaddr), .out_rfwdata(out_rfwdata),
    .mem_buserr(mem_buserr), .mem_misalign(mem_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    mem_RFWe    = 1'b0;
    mem_RFWsrc  = 2'b00;
    mem_DMre    = 1'b0;
    mem_DMwe    = 1'b0;
    mem_DMsign  = 1'b0;
    mem_DMwidth = 2'b10;
    mem_pc      = 32'd0;
    mem_aluout  = 32'd0;
    mem_rs2data = 32'd0;
    mem_rfwaddr = 5'd0;
    dm_ack      = 1'b0;
    dm_rdata    = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    nop();
    #2;
    check("rst_req", {31'd0, dm_req}, 32'd0);
    check("rst_we", {31'd0, dm_we}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_rfwe", {31'd0, out_RFWe}, 32'd0);
    check("rst_buserr", {31'd0, mem_buserr}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // PC+4 writeback, no memory access
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b11;
    mem_pc = 32'h40; mem_rfwaddr = 5'd5;
    #1;
    check("jal_data", out_rfwdata, 32'h44);
    check("jal_we", {31'd0, out_RFWe}, 32'd1);
    check("jal_addr", {27'd0, out_rfwaddr}, 32'd5);
    check("jal_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("jal_noreq", {31'd0, dm_req}, 32'd0);
    mem_RFWsrc = 2'b01; mem_aluout = 32'h1234_5678;
    #1;
    check("alu_data", out_rfwdata, 32'h1234_5678);
    mem_RFWsrc = 2'b10;
    #1;
    check("dmsrc_noacc", out_rfwdata, 32'd0);
    mem_RFWsrc = 2'b00;
    #1;
    check("nosrc", out_rfwdata, 32'd0);
    tick();
    check("alu_noreq", {31'd0, dm_req}, 32'd0);

    // LB 0x103, sign-extended
    nop();
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b10; mem_DMre = 1'b1;
    mem_DMsign = 1'b1; mem_DMwidth = 2'b00;
    mem_aluout = 32'h103; mem_rfwaddr = 5'd7;
    #1;
    check("lb_idle_stall", {31'd0, mem_stall}, 32'd1);
    check("lb_idle_rfwe", {31'd0, out_RFWe}, 32'd0);
    check("lb_be", {28'd0, dm_be}, 32'b1000);
    check("lb_addr", dm_addr, 32'h100);
    tick();
    check("lb_req", {31'd0, dm_req}, 32'd1);
    check("lb_req_we", {31'd0, dm_we}, 32'd0);
    check("lb_req_stall", {31'd0, mem_stall}, 32'd1);
    dm_ack = 1'b1; dm_rdata = 32'h80FF_1234;
    tick();
    dm_ack = 1'b0; dm_rdata = 32'd0;
    #1;
    check("lb_done_stall", {31'd0, mem_stall}, 32'd0);
    check("lb_done_req", {31'd0, dm_req}, 32'd0);
    check("lb_done_rfwe", {31'd0, out_RFWe}, 32'd1);
    check("lb_data", out_rfwdata, 32'hFFFF_FF80);
    tick();
    nop();

    // LHU 0x202
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b10; mem_DMre = 1'b1;
    mem_DMsign = 1'b0; mem_DMwidth = 2'b01;
    mem_aluout = 32'h202;
    #1;
    check("lhu_addr", dm_addr, 32'h200);
    check("lhu_be", {28'd0, dm_be}, 32'b1100);
    tick();
    dm_ack = 1'b1; dm_rdata = 32'hBEEF_0000;
    tick();
    dm_ack = 1'b0;
    #1;
    check("lhu_data", out_rfwdata, 32'h0000_BEEF);
    tick();
    nop();

    // LH 0x200, sign-extended low half
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b10; mem_DMre = 1'b1;
    mem_DMsign = 1'b1; mem_DMwidth = 2'b01;
    mem_aluout = 32'h200;
    tick();
    dm_ack = 1'b1; dm_rdata = 32'h1234_8001;
    tick();
    dm_ack = 1'b0;
    #1;
    check("lh_data", out_rfwdata, 32'hFFFF_8001);
    tick();
    nop();

    // SB 0x101
    mem_DMwe = 1'b1; mem_DMwidth = 2'b00;
    mem_aluout = 32'h101; mem_rs2data = 32'h0000_00A5;
    #1;
    check("sb_be", {28'd0, dm_be}, 32'b0010);
    check("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
    check("sb_rfwe", {31'd0, out_RFWe}, 32'd0);
    tick();
    check("sb_we", {31'd0, dm_we}, 32'd1);
    check("sb_req", {31'd0, dm_req}, 32'd1);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    #1;
    check("sb_done_rfwe", {31'd0, out_RFWe}, 32'd0);
    check("sb_done_we", {31'd0, dm_we}, 32'd0);
    tick();
    nop();

    // LW with no ack: timeout on 4th REQ cycle
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b10; mem_DMre = 1'b1;
    mem_DMwidth = 2'b10; mem_aluout = 32'h300;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("to_early_err", {31'd0, mem_buserr}, 32'd0);
      check("to_early_req", {31'd0, dm_req}, 32'd1);
      tick();
    end
    check("to_err", {31'd0, mem_buserr}, 32'd1);
    check("to_req4", {31'd0, dm_req}, 32'd1);
    tick();
    check("to_done_err", {31'd0, mem_buserr}, 32'd0);
    check("to_done_rfwe", {31'd0, out_RFWe}, 32'd0);
    check("to_done_stall", {31'd0, mem_stall}, 32'd0);
    check("to_done_req", {31'd0, dm_req}, 32'd0);
    tick();
    nop();

    // LW 0x102: trapped, or forced aligned
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b10; mem_DMre = 1'b1;
    mem_DMwidth = 2'b10; mem_aluout = 32'h102;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_flag", {31'd0, mem_misalign}, 32'd1);
    check("mis_stall", {31'd0, mem_stall}, 32'd0);
    check("mis_rfwe", {31'd0, out_RFWe}, 32'd0);
    tick();
    check("mis_noreq", {31'd0, dm_req}, 32'd0);
    nop();
`else
    check("mis_flag", {31'd0, mem_misalign}, 32'd0);
    check("mis_addr", dm_addr, 32'h100);
    check("mis_be", {28'd0, dm_be}, 32'b1111);
    check("mis_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    check("mis_req", {31'd0, dm_req}, 32'd1);
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    tick();
    dm_ack = 1'b0;
    #1;
    check("mis_data", out_rfwdata, 32'hCAFE_F00D);
    tick();
    nop();
`endif

    // Reset between edges during REQ
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b10; mem_DMre = 1'b1;
    mem_DMwidth = 2'b10; mem_aluout = 32'h400;
    tick();
    check("rr_req", {31'd0, dm_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rr_req_drop", {31'd0, dm_req}, 32'd0);
    check("rr_stall", {31'd0, mem_stall}, 32'd0);
    check("rr_rfwe", {31'd0, out_RFWe}, 32'd0);
    nop();
    mem_RFWsrc = 2'b10;
    tick();
    rst = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_ack = 1'b0;
    #1;
    check("rr_late_req", {31'd0, dm_req}, 32'd0);
    check("rr_late_rfwe", {31'd0, out_RFWe}, 32'd0);
    check("rr_late_data", out_rfwdata, 32'd0);
    mem_RFWe = 1'b1; mem_RFWsrc = 2'b11; mem_pc = 32'h80;
    #1;
    check("rr_idle_stall", {31'd0, mem_stall}, 32'd0);
    check("rr_idle_data", out_rfwdata, 32'h84);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Drives the data-memory request/ack bus for loads and stores. Aligns store data and builds byte enables. Sign- or zero-extends load data.
- Selects the register-file write data and stalls the upstream pipeline while a bus access is outstanding.

Parameters:
- WAIT_MAX, 255: maximum cycles in REQ before a bus-error abort; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- mem_RFWe  in  1  register-file write enable from EX/MEM
- mem_RFWsrc  in  2  write-data source: 00 none, 01 ALU, 10 DM, 11 PC+4
- mem_DMre  in  1  load
- mem_DMwe  in  1  store
- mem_DMsign  in  1  1 = sign-extend load
- mem_DMwidth  in  2  00 byte, 01 half, 10 word; 11 treated as word
- mem_pc  in  32  instruction PC
- mem_aluout  in  32  ALU result / effective address
- mem_rs2data  in  32  store data
- mem_rfwaddr  in  5  destination register
- dm_rdata  in  32  memory read data, valid with dm_ack
- dm_ack  in  1  access-complete pulse
- dm_req  out  1  access request; registered
- dm_we  out  1  write strobe; valid with dm_req
- dm_addr  out  32  word address: mem_aluout with bits [1:0] = 0
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-shifted store data
- mem_stall  out  1  hold PC/IF/ID/EX/MEM registers
- out_RFWe  out  1  to MEM/WB
- out_rfwaddr  out  5  to MEM/WB
- out_rfwdata  out  32  to MEM/WB
- mem_buserr  out  1  one-cycle pulse on timeout abort
- mem_misalign  out  1  misaligned-access pulse; tied 0 unless the optional feature is enabled

Behaviour:
- Reset (async, rst=1): state IDLE; dm_req=0; dm_we=0; wait counter=0; load register=0; mem_buserr=0.
- Reset (async, rst=1), combinational outputs: mem_stall=0; out_RFWe=0.
- Reset mid-access: the request is dropped immediately. No ack is awaited after release.
- FSM states: IDLE, REQ, DONE.
- IDLE, access present (DMre|DMwe): mem_stall=1, out_RFWe=0. Next state REQ, dm_req<=1, counter<=0.
- IDLE, no access: mem_stall=0. out_* pass through combinationally.
- Write-data mux: 01 -> mem_aluout; 11 -> mem_pc+4; 00 -> 0; 10 without an access -> 0.
- REQ: dm_req=1, mem_stall=1, out_RFWe=0. Address, be, wdata and we held stable.
- REQ, dm_ack=1: capture dm_rdata; next state DONE, dm_req<=0.
- REQ, no ack: counter increments. When counter reaches WAIT_MAX-1 without ack: mem_buserr=1 for that cycle, next state DONE with the result suppressed (out_RFWe=0 in DONE).
- dm_ack seen in IDLE or DONE is ignored.
- DONE: mem_stall=0. out_RFWe=mem_RFWe, unless the access aborted. For loads, out_rfwdata = extended captured data. Next state IDLE.
- Minimum access latency: 3 cycles (IDLE, REQ with ack, DONE). The next instruction is presented in the cycle after DONE.
- Byte enables by width and addr[1:0]: byte -> 0001 shifted left by addr[1:0]; half -> 0011 shifted by {addr[1],0}; word -> 1111.
- Store data: byte -> rs2[7:0] replicated to all 4 lanes; half -> rs2[15:0] replicated to both halves; word -> rs2.
- Load data: select lane by addr[1:0] (half by addr[1]). Sign- or zero-extend per mem_DMsign. Word loads pass through unchanged.
- Misaligned half/word without the optional feature: low address bits are forced aligned (half ignores addr[0]; word ignores addr[1:0]). No error is raised.
- DMre and DMwe both set: treated as a store; no register write data from memory.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Enabled: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is trapped. In IDLE: no bus request; mem_misalign=1 for one cycle; out_RFWe=0; mem_stall=0 (instruction retires as a bubble).
- Disabled: mem_misalign is constant 0; forced-alignment rule applies.

Test Plan:
- Reset during REQ (dm_req=1), rst asserted between clock edges -> dm_req=0 and mem_stall=0 immediately; state IDLE after release; a late dm_ack causes no write.
- LB addr 0x103, dm_rdata 0x80FF_1234, sign=1 -> dm_be=1000; out_rfwdata=0xFFFF_FF80 in DONE; mem_stall high 2 cycles.
- LHU addr 0x202, dm_rdata 0xBEEF_0000 -> out_rfwdata=0x0000_BEEF; dm_addr=0x200.
- SB addr 0x101, rs2=0x0000_00A5 -> dm_be=0010, dm_wdata=0xA5A5_A5A5, dm_we=1; out_RFWe=0.
- ALU op, RFWsrc=11, pc=0x40 -> out_rfwdata=0x44 same cycle; mem_stall=0; dm_req never asserts.
- WAIT_MAX=4, no ack -> mem_buserr pulse on 4th REQ cycle; DONE with out_RFWe=0. With MEM_MISALIGN_TRAP_EN: LW addr 0x102 -> mem_misalign=1, dm_req stays 0.
